seq_pattern_gen: RTL and testbench
==================================

Name: seq_pattern_gen

Overview:
Serial pattern transmitter: the driving end for the serial sequence detectors (CLK/RST/IN/MATCH style) in this benchmark set. Captures a parallel pattern and shifts it out MSB-first, one bit per CLK, with optional repetition and an idle gap between repetitions. Its OUT connects directly to a detector's IN, so detector stimulus is produced in hardware rather than by hand-written bench delays.

Parameters:
MAX_LEN, 16, maximum pattern length in bits (≥2)
LEN_W, 5, width of LEN; must hold MAX_LEN
REP_W, 4, width of REPEAT
GAP_W, 4, width of GAP

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous, active-high reset
START  input  1  request transmission; sampled only in IDLE
ABORT  input  1  synchronous cancel of an active transmission
PATTERN  input  MAX_LEN  bits to send; bit LEN-1 sent first
LEN  input  LEN_W  number of pattern bits, 1..MAX_LEN
REPEAT  input  REP_W  extra repetitions; total sends = REPEAT+1
GAP  input  GAP_W  idle cycles between repetitions (0 = back-to-back)
OUT  output  1  serial data, registered
OUT_VALID  output  1  OUT carries a pattern bit this cycle
BUSY  output  1  high from the cycle after accepted START until DONE/abort
DONE  output  1  one-cycle pulse after last bit of last repetition
ERR  output  1  one-cycle pulse: START rejected (LEN=0 or LEN>MAX_LEN)

Behaviour:
- Reset (RST=1 at edge): state IDLE; OUT=0, OUT_VALID=0, BUSY=0, DONE=0, ERR=0; counters and capture registers cleared. RST overrides START and ABORT.
- All outputs registered; no combinational input-to-output paths.
- States: IDLE, SHIFT, GAP, FIN.
- IDLE: START=1 and 1≤LEN≤MAX_LEN → capture PATTERN, LEN, REPEAT, GAP; go to SHIFT. The first bit, PATTERN[LEN-1], appears on OUT with OUT_VALID=1 and BUSY=1 in the cycle after the START edge (latency 1).
- START with an invalid LEN → ERR=1 for one cycle; remain in IDLE.
- SHIFT: one bit per cycle, indices LEN-1 down to 0. After bit 0:
  - repetitions remain, GAP>0 → GAP.
  - repetitions remain, GAP=0 → bit LEN-1 the very next cycle (no bubble).
  - no repetitions remain → FIN.
- GAP: exactly GAP cycles with OUT=0, OUT_VALID=0, BUSY=1; then SHIFT from bit LEN-1.
- FIN: one cycle with DONE=1, BUSY=0, OUT_VALID=0, OUT=0; then IDLE.
  - A START in the FIN cycle is ignored.
  - START is accepted again from the following IDLE cycle.
- START while BUSY: ignored. Input changes after capture have no effect on the transmission in progress.
- ABORT while BUSY (SHIFT or GAP): next cycle goes to IDLE with OUT=0, OUT_VALID=0, BUSY=0; no DONE pulse. ABORT in IDLE or FIN has no effect. If ABORT and START are both high in IDLE, START is accepted.
- OUT=0 whenever OUT_VALID=0.
- LEN=1: single-bit pattern; the repeat and gap rules above still apply.
- Repeat counter counts down from REPEAT to 0; no wrap-around.
- Total bursts = REPEAT+1, up to 2^REP_W.
- Bit index and gap counter never wrap; both are reloaded at each repetition.

Decomposition:
- Package seq_gen_pkg: state enum (IDLE, SHIFT, GAP, FIN), default widths, and MSB-first as a constant.
- One sub-module, seq_gen_shreg: loadable MAX_LEN-bit shift register with bit counter.
  - Inputs: load, shift, pattern, len.
  - Outputs: serial bit, last_bit.
- The top level holds the FSM, repeat counter and gap counter.

Test Plan:
1. PATTERN=0x0071, LEN=8, REPEAT=0, GAP=0, START pulse → OUT sequence 0,1,1,1,0,0,0,1 with OUT_VALID high for 8 cycles starting 1 cycle after START; DONE pulses on the 9th cycle. A connected fsm4-style detector raises MATCH.
2. PATTERN=0b101, LEN=3, REPEAT=2, GAP=2 → 1,0,1,(gap),(gap),1,0,1,(gap),(gap),1,0,1; OUT_VALID low exactly during the 4 gap cycles; BUSY high for 13 cycles; one DONE.
3. PATTERN=0b10, LEN=2, REPEAT=1, GAP=0 → 1,0,1,0 back-to-back, OUT_VALID continuously high for 4 cycles.
4. LEN=0 START → ERR pulse, BUSY stays 0. LEN=17 (MAX_LEN=16) → ERR pulse, no output.
5. ABORT asserted on the 3rd bit of an 8-bit send → next cycle OUT_VALID=0, BUSY=0, no DONE. A new START the following cycle is accepted, and its first bit appears 1 cycle later.
6. RST asserted mid-SHIFT (with START also high) → all outputs 0 next cycle, state IDLE. A START during BUSY (PATTERN changed) is ignored, and the original pattern completes unchanged.

Source files
------------

// File: rtl/seq_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_gen_pkg
// Purpose  : Shared state encoding and default sizes for the serial pattern generator.
// Revision : 1.0 - initial release
// ============================================================================
package seq_gen_pkg;

   localparam int c_max_len = 16;
   localparam int c_len_w   = 5;
   localparam int c_rep_w   = 4;
   localparam int c_gap_w   = 4;

   localparam bit c_msb_first = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_gen_shreg.sv
`default_nettype none
// ============================================================================
// Module   : seq_gen_shreg
// Purpose  : Loadable pattern shift register with remaining-bit counter.
// Revision : 1.0 - initial release
// ============================================================================
module seq_gen_shreg
   import seq_gen_pkg::*;
#(
   parameter int MAX_LEN = c_max_len,
   parameter int LEN_W   = c_len_w
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               shift,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   len,
   output logic               serial,
   output logic               last_bit
);

   localparam logic [LEN_W-1:0] c_width = LEN_W'(MAX_LEN);

   logic [MAX_LEN-1:0] r_data;
   logic [LEN_W-1:0]   r_cnt;
   logic [MAX_LEN-1:0] w_load_val;
   logic [MAX_LEN-1:0] w_shifted;
   logic [MAX_LEN-1:0] w_data_nxt;

   // serial is the bit that r_data will present after this edge, so the
   // parent can register it alongside its own state update.
   generate
      if (c_msb_first) begin : g_msb_first
         assign w_load_val = pattern << (c_width - len);
         assign w_shifted  = {r_data[MAX_LEN-2:0], 1'b0};
         assign serial     = w_data_nxt[MAX_LEN-1];
      end else begin : g_lsb_first
         assign w_load_val = pattern;
         assign w_shifted  = {1'b0, r_data[MAX_LEN-1:1]};
         assign serial     = w_data_nxt[0];
      end
   endgenerate

   always_comb begin
      w_data_nxt = r_data;
      if (load) begin
         w_data_nxt = w_load_val;
      end else if (shift) begin
         w_data_nxt = w_shifted;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= '0;
         r_cnt  <= '0;
      end else begin
         r_data <= w_data_nxt;
         if (load) begin
            r_cnt <= len - 1'b1;
         end else if (shift && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign last_bit = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_gen
// Purpose  : Serial pattern transmitter with repeat count and inter-burst gap.
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_gen
   import seq_gen_pkg::*;
#(
   parameter int MAX_LEN = c_max_len,
   parameter int LEN_W   = c_len_w,
   parameter int REP_W   = c_rep_w,
   parameter int GAP_W   = c_gap_w
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               START,
   input  logic               ABORT,
   input  logic [MAX_LEN-1:0] PATTERN,
   input  logic [LEN_W-1:0]   LEN,
   input  logic [REP_W-1:0]   REPEAT,
   input  logic [GAP_W-1:0]   GAP,
   output logic               OUT,
   output logic               OUT_VALID,
   output logic               BUSY,
   output logic               DONE,
   output logic               ERR
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [MAX_LEN-1:0] r_pat;
   logic [LEN_W-1:0]   r_len;
   logic [REP_W-1:0]   r_rep;
   logic [GAP_W-1:0]   r_gap_len;
   logic [GAP_W-1:0]   r_gap_cnt;
   logic               r_out;
   logic               r_out_valid;
   logic               r_busy;
   logic               r_done;
   logic               r_err;

   logic               w_len_ok;
   logic               w_capture;
   logic               w_load;
   logic               w_use_cap;
   logic               w_shift;
   logic               w_rep_dec;
   logic               w_gap_load;
   logic               w_gap_dec;
   logic               w_err;
   logic [MAX_LEN-1:0] w_sr_pat;
   logic [LEN_W-1:0]   w_sr_len;
   logic               w_bit;
   logic               w_last;

   assign w_len_ok = (LEN != '0) && (LEN <= LEN_W'(MAX_LEN));

   // Repetitions reload from the captured copy so later input changes are ignored.
   assign w_sr_pat = w_use_cap ? r_pat : PATTERN;
   assign w_sr_len = w_use_cap ? r_len : LEN;

   seq_gen_shreg #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_shreg (
      .clk      (CLK),
      .rst      (RST),
      .load     (w_load),
      .shift    (w_shift),
      .pattern  (w_sr_pat),
      .len      (w_sr_len),
      .serial   (w_bit),
      .last_bit (w_last)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_load      = 1'b0;
      w_use_cap   = 1'b0;
      w_shift     = 1'b0;
      w_rep_dec   = 1'b0;
      w_gap_load  = 1'b0;
      w_gap_dec   = 1'b0;
      w_err       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (START) begin
               if (w_len_ok) begin
                  w_capture   = 1'b1;
                  w_load      = 1'b1;
                  w_state_nxt = ST_SHIFT;
               end else begin
                  w_err = 1'b1;
               end
            end
         end
         ST_SHIFT: begin
            if (ABORT) begin
               w_state_nxt = ST_IDLE;
            end else if (!w_last) begin
               w_shift = 1'b1;
            end else if (r_rep != '0) begin
               w_rep_dec = 1'b1;
               if (r_gap_len != '0) begin
                  w_gap_load  = 1'b1;
                  w_state_nxt = ST_GAP;
               end else begin
                  w_load    = 1'b1;
                  w_use_cap = 1'b1;
               end
            end else begin
               w_state_nxt = ST_FIN;
            end
         end
         ST_GAP: begin
            if (ABORT) begin
               w_state_nxt = ST_IDLE;
            end else if (r_gap_cnt <= GAP_W'(1)) begin
               w_load      = 1'b1;
               w_use_cap   = 1'b1;
               w_state_nxt = ST_SHIFT;
            end else begin
               w_gap_dec = 1'b1;
            end
         end
         ST_FIN: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= ST_IDLE;
         r_pat       <= '0;
         r_len       <= '0;
         r_rep       <= '0;
         r_gap_len   <= '0;
         r_gap_cnt   <= '0;
         r_out       <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_capture) begin
            r_pat     <= PATTERN;
            r_len     <= LEN;
            r_rep     <= REPEAT;
            r_gap_len <= GAP;
         end else if (w_rep_dec) begin
            r_rep <= r_rep - 1'b1;
         end
         if (w_gap_load) begin
            r_gap_cnt <= r_gap_len;
         end else if (w_gap_dec) begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
         end
         // Outputs describe the state being entered, keeping them fully registered.
         r_out_valid <= (w_state_nxt == ST_SHIFT);
         r_out       <= (w_state_nxt == ST_SHIFT) && w_bit;
         r_busy      <= (w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_GAP);
         r_done      <= (w_state_nxt == ST_FIN);
         r_err       <= w_err;
      end
   end

   assign OUT       = r_out;
   assign OUT_VALID = r_out_valid;
   assign BUSY      = r_busy;
   assign DONE      = r_done;
   assign ERR       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_pattern_gen
// Purpose  : Scoreboard bench comparing every cycle against a trace-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_gen;

   localparam int MAX_LEN = 16;
   localparam int LEN_W   = 5;
   localparam int REP_W   = 4;
   localparam int GAP_W   = 4;

   logic               CLK = 1'b0;
   logic               RST;
   logic               START;
   logic               ABORT;
   logic [MAX_LEN-1:0] PATTERN;
   logic [LEN_W-1:0]   LEN;
   logic [REP_W-1:0]   REPEAT;
   logic [GAP_W-1:0]   GAP;
   logic               OUT;
   logic               OUT_VALID;
   logic               BUSY;
   logic               DONE;
   logic               ERR;

   seq_pattern_gen #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W),
      .REP_W   (REP_W),
      .GAP_W   (GAP_W)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .START     (START),
      .ABORT     (ABORT),
      .PATTERN   (PATTERN),
      .LEN       (LEN),
      .REPEAT    (REPEAT),
      .GAP       (GAP),
      .OUT       (OUT),
      .OUT_VALID (OUT_VALID),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .ERR       (ERR)
   );

   always #5 CLK = ~CLK;

   // Expected per-cycle vector: {valid, out, busy, done, err}; empty queue means idle.
   logic [4:0] exp_q[$];
   logic [4:0] tr[$];
   logic [4:0] mon_e;
   logic [4:0] mon_a;
   int         checks = 0;
   int         errors = 0;
   bit         mon_en = 1'b0;

   always @(negedge CLK) begin
      if (mon_en) begin
         mon_e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'b00000;
         mon_a = {OUT_VALID, OUT, BUSY, DONE, ERR};
         checks++;
         if (mon_a !== mon_e) begin
            errors++;
            $display("FAIL outputs @%0t {valid,out,busy,done,err} got %b expected %b",
                     $time, mon_a, mon_e);
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Reference: the cycle-by-cycle response to one START, from the transmit rules.
   task automatic build(input logic [MAX_LEN-1:0] p, input int l, input int r, input int g);
      tr.delete();
      if (l < 1 || l > MAX_LEN) begin
         tr.push_back(5'b00001);
         return;
      end
      for (int rr = 0; rr <= r; rr++) begin
         for (int i = l - 1; i >= 0; i--) tr.push_back({1'b1, p[i], 1'b1, 2'b00});
         if (rr < r) for (int k = 0; k < g; k++) tr.push_back(5'b00100);
      end
      tr.push_back(5'b00010);
   endtask

   task automatic run(input logic [MAX_LEN-1:0] p, input int l, input int r, input int g,
                      input int abort_at, input int rst_at, input bit noise_in);
      int n;
      bit noise;
      noise   = noise_in && (l >= 1) && (l <= MAX_LEN);
      PATTERN = p;
      LEN     = LEN_W'(l);
      REPEAT  = REP_W'(r);
      GAP     = GAP_W'(g);
      START   = 1'b1;
      ABORT   = 1'($urandom_range(0, 1));
      build(p, l, r, g);
      if (abort_at >= 0 && abort_at < tr.size() - 1)
         while (tr.size() > abort_at + 1) void'(tr.pop_back());
      tick();
      foreach (tr[i]) exp_q.push_back(tr[i]);
      START = 1'b0;
      ABORT = 1'b0;
      n = tr.size();
      for (int t = 0; t < n; t++) begin
         if (noise) begin
            START   = 1'($urandom_range(0, 1));
            PATTERN = MAX_LEN'($urandom);
            LEN     = LEN_W'($urandom);
            REPEAT  = REP_W'($urandom);
            GAP     = GAP_W'($urandom);
         end
         ABORT = (t == abort_at);
         if (t == rst_at) begin
            RST   = 1'b1;
            START = 1'b1;
            LEN   = LEN_W'(4);
         end
         tick();
         if (t == rst_at) begin
            RST = 1'b0;
            exp_q.delete();
            break;
         end
      end
      START = 1'b0;
      ABORT = 1'b0;
   endtask

   initial begin
      RST     = 1'b1;
      START   = 1'b0;
      ABORT   = 1'b0;
      PATTERN = '0;
      LEN     = '0;
      REPEAT  = '0;
      GAP     = '0;
      tick();
      mon_en = 1'b1;
      tick();
      RST = 1'b0;
      tick();

      run(16'h0071, 8, 0, 0, -1, -1, 1'b0);
      run(16'h0005, 3, 2, 2, -1, -1, 1'b0);
      run(16'h0002, 2, 1, 0, -1, -1, 1'b0);
      run(16'h00FF, 0, 0, 0, -1, -1, 1'b0);
      run(16'hFFFF, 17, 0, 0, -1, -1, 1'b0);
      run(16'h00A5, 8, 0, 0, 2, -1, 1'b0);
      run(16'h003C, 8, 0, 0, -1, -1, 1'b0);
      run(16'hBEEF, 16, 1, 3, -1, 5, 1'b0);
      run(16'h00C3, 8, 1, 1, -1, -1, 1'b1);
      run(16'h0001, 1, 2, 1, -1, -1, 1'b0);
      run(16'h0000, 1, 1, 0, -1, -1, 1'b0);
      run(16'h8001, 16, 0, 0, -1, -1, 1'b0);
      run(16'h0123, 12, 2, 3, 20, -1, 1'b0);

      for (int k = 0; k < 40; k++) begin
         int l, r, g, ab, rs;
         l  = $urandom_range(0, 17);
         r  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
         g  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : -1;
         rs = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 30) : -1;
         run(MAX_LEN'($urandom), l, r, g, ab, rs, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) tick();
      end

      repeat (3) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected cycles left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
